sprite_scaler: RTL
==================

SPRITE_SCALER -- requirements
Module: sprite_scaler

Interface
REQ-001 SHALL have parameter SPR_W, default 32: sprite width in ROM texels.
REQ-002 SHALL have parameter SPR_H, default 32: sprite height in ROM texels.
REQ-003 SHALL have parameter SCALE_X, default 2: horizontal pixel replication factor, 1..16.
REQ-004 SHALL have parameter SCALE_Y, default 2: vertical line replication factor, 1..16.
REQ-005 SHALL have parameter ADDR_W, default 17: ROM address width, with 2^ADDR_W >= SPR_W*SPR_H.
REQ-006 SHALL have parameter IDX_W, default 8: palette index width.
REQ-007 SHALL have parameter TRANSP_IDX, default 0: palette index treated as transparent.
REQ-008 Ports, in this order: vga_clk in 1, pixel clock and the only clock; Reset in 1, synchronous active-high reset.
REQ-009 DrawX, DrawY in 10 each: current scan position, 0..799 by 0..524.
REQ-010 blank in 1: high in the visible region.
REQ-011 sprite_x, sprite_y in 10 each: requested top-left screen position.
REQ-012 flip_x in 1: horizontal mirror request (see Configuration).
REQ-013 rom_address out ADDR_W: texel address to the external synchronous ROM.
REQ-014 rom_q in IDX_W: ROM data, valid one vga_clk after rom_address.
REQ-015 pix_idx out IDX_W: palette index of the sprite pixel.
REQ-016 pix_hit out 1: pixel is inside the sprite, visible, and not transparent.
REQ-017 blank_d out 1: blank delayed to align with pix_idx and pix_hit.

Function
REQ-018 SHALL latch sprite_x, sprite_y, and flip_x into shadow registers only on the cycle DrawX==0 && DrawY==0; mid-frame changes SHALL NOT take effect until the next frame.
REQ-019 Vertical tracking SHALL update once per line, on DrawX==0.
- REQ-019a If DrawY equals shadow y: row=0, vrep=0, row_active=1.
- REQ-019b Else if row_active: vrep increments; at vrep==SCALE_Y-1, vrep resets to 0 and row increments.
- REQ-019c At row==SPR_H-1 with vrep==SCALE_Y-1, row_active clears.
REQ-020 SHALL maintain row_base = row*SPR_W by adding SPR_W on each row increment; no multiplier or divider is permitted.
REQ-021 Horizontal tracking SHALL run only while row_active.
- REQ-021a When DrawX equals shadow x: col=0, hrep=0, inside=1.
- REQ-021b Each subsequent cycle: hrep increments; at hrep==SCALE_X-1, hrep resets to 0 and col increments.
- REQ-021c The cycle after col==SPR_W-1 with hrep==SCALE_X-1, inside clears.
REQ-022 A sprite SHALL occupy exactly SPR_W*SCALE_X pixels by SPR_H*SCALE_Y lines.
REQ-023 Stage 1, at cycle N+1 for DrawX sampled at cycle N: registered rom_address = row_base + col, or row_base + (SPR_W-1-col) when mirroring is active.
REQ-024 Stage 2, at N+2: rom_q is returned by the ROM.
REQ-025 Stage 3, at N+3: pix_idx<=rom_q, pix_hit<=inside_d2 & blank_d2 & (rom_q!=TRANSP_IDX), blank_d<=blank_d2. Total latency SHALL be 3 cycles.
REQ-026 When inside is low, rom_address SHALL hold its last value and pix_hit SHALL be 0.
REQ-027 Clipping: a sprite extending past x=639 or y=479 SHALL be cut by blank.
- No wrap-around to the left edge or top.
- Counters continue through blanking without corrupting the next line.
REQ-028 Shadow x >= 800 or shadow y >= 525 SHALL produce no hits for that frame.
REQ-029 A new frame latch coinciding with an active row SHALL take priority; row state SHALL restart from the new shadow values.

Reset
REQ-030 On Reset high at a vga_clk edge, the following SHALL clear to 0: shadows, row, col, vrep, hrep, row_base, row_active, inside, all pipeline stages, rom_address, pix_idx, pix_hit, blank_d.
REQ-031 After Reset deasserts mid-frame, pix_hit SHALL stay 0 until the following frame latch.
REQ-032 Reset held for any length SHALL leave all outputs at 0.

Configuration
REQ-033 Macro SPRITE_MIRROR_EN defined: flip_x is latched per REQ-018 and applied per REQ-023.
REQ-034 Macro SPRITE_MIRROR_EN undefined: the flip_x port SHALL still exist but be ignored, and addressing SHALL always be unmirrored.

Verification
REQ-035 SPR_W=4, SPR_H=2, SCALE_X=2, SCALE_Y=3, sprite at (10,20), full 800x525 sweep.
- Required: pix_hit only for x 10..17 and y 20..25, 3 cycles late.
- Required: rom_address sequence on line 20 is 0,0,1,1,2,2,3,3; on line 23 it is 4,4,5,5,6,6,7,7.
REQ-036 rom_q==TRANSP_IDX on texel 2 -> pix_hit=0 at x=14,15 on every covered line; all other sprite pixels give pix_hit=1.
REQ-037 sprite_x changes from 10 to 50 at DrawY=22 -> remainder of the current frame still at x=10; next frame at x=50.
REQ-038 Sprite at (636,478) -> hits only at x 636..639 and y 478..479; next frame's line 0 shows no hits.
REQ-039 With SPRITE_MIRROR_EN and flip_x=1, line 20 addresses are 3,3,2,2,1,1,0,0; with the macro undefined, addresses are 0,0,1,1,2,2,3,3.
REQ-040 Reset pulse at DrawY=21 -> all outputs 0 the next cycle, no hits for the rest of the frame, normal output resumes next frame.

Source files
------------

// File: rtl/sprite_scaler.sv
// Integer-scaled sprite fetch: screen position -> ROM texel address, 3-cycle pixel pipeline.
// Define SPRITE_MIRROR_EN to honour flip_x (horizontal mirroring); otherwise flip_x is ignored.
module sprite_scaler #(
    parameter int SPR_W      = 32,
    parameter int SPR_H      = 32,
    parameter int SCALE_X    = 2,
    parameter int SCALE_Y    = 2,
    parameter int ADDR_W     = 17,
    parameter int IDX_W      = 8,
    parameter int TRANSP_IDX = 0
) (
    input  logic              vga_clk,
    input  logic              Reset,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              blank,
    input  logic [9:0]        sprite_x,
    input  logic [9:0]        sprite_y,
    input  logic              flip_x,
    output logic [ADDR_W-1:0] rom_address,
    input  logic [IDX_W-1:0]  rom_q,
    output logic [IDX_W-1:0]  pix_idx,
    output logic              pix_hit,
    output logic              blank_d
);
    localparam int CW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam int RW = (SPR_H > 1) ? $clog2(SPR_H) : 1;
    localparam logic [CW-1:0]     COL_LAST  = CW'(SPR_W - 1);
    localparam logic [RW-1:0]     ROW_LAST  = RW'(SPR_H - 1);
    localparam logic [3:0]        HREP_LAST = 4'(SCALE_X - 1);
    localparam logic [3:0]        VREP_LAST = 4'(SCALE_Y - 1);
    localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(SPR_W);
    localparam logic [IDX_W-1:0]  TRANSP    = IDX_W'(TRANSP_IDX);

    logic [9:0]        shadow_x, shadow_y;
    logic              frame_ok;
    logic [RW-1:0]     row_r, row_c;
    logic [3:0]        vrep_r, vrep_c;
    logic [ADDR_W-1:0] row_base_r, base_c;
    logic              row_active_r, ract_c;
    logic [CW-1:0]     col_r, col_c, col_n, col_addr;
    logic [3:0]        hrep_r, hrep_c, hrep_n;
    logic              inside_r, in_c, in_n;
    logic              inside_d1, inside_d2, blank_d1, blank_d2;
    logic              frame_start, line_start, ok_eff, flip_eff;
    logic [9:0]        sx_eff, sy_eff;
    logic [ADDR_W-1:0] addr_c;

    assign line_start  = (DrawX == 10'd0);
    assign frame_start = line_start && (DrawY == 10'd0);
    // The frame latch takes effect on the same cycle it is sampled
    assign sx_eff = frame_start ? sprite_x : shadow_x;
    assign sy_eff = frame_start ? sprite_y : shadow_y;
    assign ok_eff = frame_start | frame_ok;

`ifdef SPRITE_MIRROR_EN
    logic shadow_flip;
    assign flip_eff = frame_start ? flip_x : shadow_flip;

    always_ff @(posedge vga_clk) begin
        if (Reset)
            shadow_flip <= 1'b0;
        else if (frame_start)
            shadow_flip <= flip_x;
    end
`else
    logic unused_flip;
    assign unused_flip = flip_x;
    assign flip_eff    = 1'b0;
`endif

    // Vertical state for the current line
    always_comb begin
        row_c  = row_r;
        vrep_c = vrep_r;
        base_c = row_base_r;
        ract_c = row_active_r;
        if (frame_start) begin
            row_c  = '0;
            vrep_c = '0;
            base_c = '0;
            ract_c = 1'b0;
        end
        if (line_start) begin
            if (ok_eff && (DrawY == sy_eff)) begin
                row_c  = '0;
                vrep_c = '0;
                base_c = '0;
                ract_c = 1'b1;
            end else if (ract_c) begin
                if (vrep_c == VREP_LAST) begin
                    vrep_c = '0;
                    if (row_c == ROW_LAST) begin
                        ract_c = 1'b0;
                    end else begin
                        row_c  = row_c + RW'(1);
                        base_c = base_c + ROW_STEP;
                    end
                end else begin
                    vrep_c = vrep_c + 4'd1;
                end
            end
        end
    end

    // Horizontal state for the current pixel; a new line never inherits inside
    always_comb begin
        col_c  = col_r;
        hrep_c = hrep_r;
        in_c   = inside_r & ~line_start;
        if (ract_c && (DrawX == sx_eff)) begin
            col_c  = '0;
            hrep_c = '0;
            in_c   = 1'b1;
        end
    end

    always_comb begin
        col_n  = col_c;
        hrep_n = hrep_c;
        in_n   = in_c;
        if (in_c) begin
            if (hrep_c == HREP_LAST) begin
                hrep_n = '0;
                if (col_c == COL_LAST)
                    in_n = 1'b0;
                else
                    col_n = col_c + CW'(1);
            end else begin
                hrep_n = hrep_c + 4'd1;
            end
        end
    end

    assign col_addr = flip_eff ? (COL_LAST - col_c) : col_c;
    assign addr_c   = base_c + ADDR_W'(col_addr);

    always_ff @(posedge vga_clk) begin
        if (Reset) begin
            shadow_x     <= '0;
            shadow_y     <= '0;
            frame_ok     <= 1'b0;
            row_r        <= '0;
            vrep_r       <= '0;
            row_base_r   <= '0;
            row_active_r <= 1'b0;
            col_r        <= '0;
            hrep_r       <= '0;
            inside_r     <= 1'b0;
            inside_d1    <= 1'b0;
            inside_d2    <= 1'b0;
            blank_d1     <= 1'b0;
            blank_d2     <= 1'b0;
            rom_address  <= '0;
            pix_idx      <= '0;
            pix_hit      <= 1'b0;
            blank_d      <= 1'b0;
        end else begin
            if (frame_start) begin
                shadow_x <= sprite_x;
                shadow_y <= sprite_y;
                frame_ok <= 1'b1;
            end
            row_r        <= row_c;
            vrep_r       <= vrep_c;
            row_base_r   <= base_c;
            row_active_r <= ract_c;
            col_r        <= col_n;
            hrep_r       <= hrep_n;
            inside_r     <= in_n;
            if (in_c)
                rom_address <= addr_c;
            inside_d1 <= in_c;
            blank_d1  <= blank;
            inside_d2 <= inside_d1;
            blank_d2  <= blank_d1;
            pix_idx   <= rom_q;
            pix_hit   <= inside_d2 & blank_d2 & (rom_q != TRANSP);
            blank_d   <= blank_d2;
        end
    end
endmodule
